// File: rtl/paddsub_16bit.sv
// Four-lane signed 4-bit saturating add/subtract.
// Each lane has its own carry-lookahead adder; result registered once.
module paddsub_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        is_sub,
  output logic [15:0] sum_out,
  output logic [3:0]  sat_out
);

  logic [15:0] b_eff;
  logic [15:0] lane_res;
  logic [3:0]  lane_sat;

  // Subtraction inverts B here; the +1 enters as each lane's carry-in.
  always_comb begin
    b_eff = is_sub ? ~b_in : b_in;
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic [3:0] s;
    logic       ovf;

    assign a = a_in[4*k +: 4];
    assign b = b_eff[4*k +: 4];
    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries expanded from generate/propagate.
    always_comb begin
      c[0] = is_sub;
      c[1] = g[0]
           | (p[0] & c[0]);
      c[2] = g[1]
           | (p[1] & g[0])
           | (p[1] & p[0] & c[0]);
      c[3] = g[2]
           | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
    end

    assign s = p ^ c;

    // Same-sign operands giving a flipped sign means overflow.
    assign ovf = (a[3] == b[3])
              && (s[3] != a[3]);

    // Clamp toward the operands' common sign on overflow.
    always_comb begin
      lane_sat[k] = ovf;
      if (ovf)
        lane_res[4*k +: 4] = a[3] ? 4'h8 : 4'h7;
      else
        lane_res[4*k +: 4] = s;
    end
  end

  // Output register; reset clears immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out <= 16'h0000;
      sat_out <= 4'h0;
    end else begin
      sum_out <= lane_res;
      sat_out <= lane_sat;
    end
  end

endmodule

// File: tb/tb_paddsub_16bit.sv
// Bench for paddsub_16bit: spec vectors, random vs
// arithmetic model, reset and glitch sequences.
module tb_paddsub_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        is_sub;
  logic [15:0] sum_out;
  logic [3:0]  sat_out;

  int checks = 0;
  int errors = 0;

  paddsub_16bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_in    (a_in),
    .b_in    (b_in),
    .is_sub  (is_sub),
    .sum_out (sum_out),
    .sat_out (sat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic [3:0]  sat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [15:0] got_s,
                     input logic [3:0] got_f,
                     input logic [15:0] exp_s,
                     input logic [3:0] exp_f);
    checks++;
    if (got_s !== exp_s || got_f !== exp_f) begin
      errors++;
      $display("FAIL %s: got sum=%h sat=%h want sum=%h sat=%h",
               nm, got_s, got_f, exp_s, exp_f);
    end
  endtask

  // True signed arithmetic per lane, clamped to -8..7.
  function automatic void model(input logic sub,
                                input logic [15:0] a,
                                input logic [15:0] b,
                                output logic [15:0] r,
                                output logic [3:0] f);
    r = '0;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      logic signed [3:0] ta;
      logic signed [3:0] tb;
      int va;
      int vb;
      int v;
      ta = a[4*k +: 4];
      tb = b[4*k +: 4];
      va = ta;
      vb = tb;
      v = sub ? va - vb : va + vb;
      if (v > 7) begin
        v = 7;
        f[k] = 1'b1;
      end else if (v < -8) begin
        v = -8;
        f[k] = 1'b1;
      end
      r[4*k +: 4] = v[3:0];
    end
  endfunction

  task automatic apply(input logic sub,
                       input logic [15:0] a,
                       input logic [15:0] b);
    is_sub = sub;
    a_in   = a;
    b_in   = b;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] es;
  logic [3:0]  ef;
  logic [15:0] hold_s;
  logic [3:0]  hold_f;

  initial begin
    tbl[0] = '{1'b0, 16'h1284, 16'h1111, 16'h2395, 4'h0};
    tbl[1] = '{1'b0, 16'h7777, 16'h1111, 16'h7777, 4'hF};
    tbl[2] = '{1'b0, 16'h8888, 16'h8888, 16'h8888, 4'hF};
    tbl[3] = '{1'b1, 16'h1284, 16'h1111, 16'h0183, 4'h2};
    tbl[4] = '{1'b1, 16'h0000, 16'h0008, 16'h0007, 4'h1};
    tbl[5] = '{1'b1, 16'h0007, 16'h0008, 16'h0007, 4'h1};
    tbl[6] = '{1'b0, 16'hF0F0, 16'h1111, 16'h0101, 4'h0};

    rst_n  = 1'b1;
    is_sub = 1'b0;
    a_in   = 16'h1234;
    b_in   = 16'h1111;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_async", sum_out, sat_out, 16'h0000, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", sum_out, sat_out, 16'h0000, 4'h0);

    rst_n = 1'b1;
    apply(1'b0, 16'h1234, 16'h1111);
    chk("first_edge", sum_out, sat_out, 16'h2345, 4'h0);

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].sub, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d", i), sum_out, sat_out,
          tbl[i].sum, tbl[i].sat);
    end

    for (int i = 0; i < 300; i++) begin
      logic        s;
      logic [15:0] a;
      logic [15:0] b;
      s = 1'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      model(s, a, b, es, ef);
      apply(s, a, b);
      chk($sformatf("rand%0d", i), sum_out, sat_out, es, ef);
    end

    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = {4{4'(i >> 4)}};
      b = {4{4'(i)}};
      model(i[0] ^ i[4], a, b, es, ef);
      apply(i[0] ^ i[4], a, b);
      chk($sformatf("sweep%0d", i), sum_out, sat_out, es, ef);
    end

    apply(1'b0, 16'h1111, 16'h2222);
    hold_s = sum_out;
    hold_f = sat_out;
    chk("pre_glitch", hold_s, hold_f, 16'h3333, 4'h0);
    #1 a_in = 16'h7777;
    b_in = 16'h7777;
    #1 is_sub = 1'b1;
    #1;
    chk("glitch_hold", sum_out, sat_out, hold_s, hold_f);

    apply(1'b0, 16'h1284, 16'h1111);
    chk("pre_midreset", sum_out, sat_out, 16'h2395, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_clear", sum_out, sat_out, 16'h0000, 4'h0);
    is_sub = 1'b1;
    a_in   = 16'h0000;
    b_in   = 16'h0008;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_release", sum_out, sat_out, 16'h0007, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddsub_16bit.md
PADDSUB_16BIT -- requirements
Module: paddsub_16bit

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a_in  input  16  operand A, four packed signed 4-bit nibbles; nibble k = a_in[4k+3:4k].
REQ-005 b_in  input  16  operand B, same packing as a_in.
REQ-006 is_sub  input  1  0 = per-nibble A+B; 1 = per-nibble A-B.
REQ-007 sum_out  output  16  registered per-nibble saturated result, same packing.
REQ-008 sat_out  output  4  registered flags; bit k = 1 when nibble k saturated.

Function
REQ-009 Four independent lanes, k = 0..3; no carry or borrow crosses a lane boundary.
REQ-010 Operands are two's-complement in range -8..+7.
REQ-011 Add: each lane computes A + B.
REQ-012 Subtract: each lane computes A + ~B + 1, using the lane's carry-in; 0x8 is never negated separately.
REQ-013 Each lane uses a 4-bit carry-lookahead adder (generate/propagate).
REQ-014 Overflow when both effective operands have equal sign bits and the raw 4-bit result sign differs.
REQ-015 Positive overflow (effective operands non-negative) -> lane result 0x7 and sat_out[k] = 1.
REQ-016 Negative overflow (effective operands negative) -> lane result 0x8 and sat_out[k] = 1.
REQ-017 No overflow -> lane result is the raw 4-bit sum and sat_out[k] = 0.
REQ-018 Latency is exactly 1 cycle: inputs sampled at rising edge N appear on sum_out/sat_out after edge N.
REQ-019 Outputs update on every rising edge; there is no enable and no handshake.
REQ-020 Outputs hold between edges; input glitches between edges have no effect on the outputs.

Reset
REQ-021 rst_n low immediately forces sum_out = 16'h0000 and sat_out = 4'h0, independent of clk.
REQ-022 While rst_n is low, outputs stay zero.
REQ-023 The first rising edge with rst_n high registers the current inputs.
REQ-024 Reset asserted mid-operation discards the in-flight result; nothing is retained.

Verification
REQ-025 Bench scenario: is_sub=0, a=0x1284, b=0x1111 -> after 1 edge, sum_out=0x2395, sat_out=0x0.
REQ-026 Bench scenario: is_sub=0, a=0x7777, b=0x1111 -> sum_out=0x7777, sat_out=0xF (all lanes positive-saturate).
REQ-027 Bench scenario: is_sub=0, a=0x8888, b=0x8888 -> sum_out=0x8888, sat_out=0xF (all lanes negative-saturate).
REQ-028 Bench scenario: is_sub=1, a=0x1284, b=0x1111 -> sum_out=0x0183, sat_out=0x2 (lane 1: -8-1 clamps to 0x8).
REQ-029 Bench scenario: is_sub=1, a=0x0000, b=0x0008 -> sum_out=0x0007, sat_out=0x1 (0-(-8) clamps to +7).
REQ-030 Bench scenario: drive nonzero result, assert rst_n low between edges -> outputs 0 immediately; release and clock -> result of current inputs.
